// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin burst write arbiter with flush sequencer feeding a single sync_fifo.
// Grants whole bursts (last or MAX_BURST) and pulses the FIFO's active-low reset on flush.
module sync_fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ-1:0]              last_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   data_i,
    output logic [N_REQ-1:0]              ack_o,
    input  logic                          flush_i,
    output logic                          flush_done_o,
    output logic                          busy_o,
    output logic [$clog2(N_REQ)-1:0]      owner_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic                          fifo_write_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_rst_n_o
);

    localparam int unsigned OW  = $clog2(N_REQ);
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);
    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic            flush_done_q, flush_done_d;

    logic                  req_own;
    logic                  last_own;
    logic [DATA_WIDTH-1:0] data_own;
    logic [2*N_REQ-1:0]    req_dbl;
    logic [N_REQ-1:0]      req_rot;
    logic [OW-1:0]         grant;
    logic [OW-1:0]         owner_next;
    logic                  accept;
    logic                  accept_ok;

    // Current owner's request, last flag and data word.
    always_comb begin
        req_own  = 1'b0;
        last_own = 1'b0;
        data_own = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                req_own  = req_i[i];
                last_own = last_i[i];
                data_own = data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // First requester at or after rr_ptr, searching cyclically.
    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = N_REQ'(req_dbl >> rr_ptr_q);
        grant   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant = OW'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
            end
        end
    end

    assign owner_next = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        flush_pend_d = flush_pend_q | flush_i;
        flush_done_d = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Flush wins over pending requests.
                if (flush_pend_q || flush_i) begin
                    state_d      = ST_FLUSH;
                    flush_pend_d = 1'b0;
                    flush_cnt_d  = '0;
                end else if (|req_i) begin
                    state_d    = ST_BURST;
                    owner_d    = grant;
                    beat_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (!req_own) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_next;
                end else if (!fifo_full_i) begin
                    accept     = 1'b1;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (last_own || (beat_cnt_q + BW'(1)) == BW'(MAX_BURST)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_next;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
                    state_d      = ST_IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Nothing is written while reset is asserted; the FIFO is held in reset then.
    assign accept_ok      = accept & ~rst_i;
    assign ack_o          = accept_ok ? (N_REQ'(1) << owner_q) : '0;
    assign fifo_write_o   = accept_ok;
    assign fifo_wr_data_o = accept_ok ? data_own : '0;
    assign busy_o         = (state_q != ST_IDLE);
    assign owner_o        = owner_q;
    assign flush_done_o   = flush_done_q;
    assign fifo_rst_n_o   = ~rst_i & (state_q != ST_FLUSH);

endmodule
